flu_wb_scheduler: RTL and testbench
===================================

FLU_WB_SCHEDULER -- requirements
Module: flu_wb_scheduler

Interface
REQ-001 SHALL have parameter MAX_LAT, default 4: largest fixed latency in cycles; legal range 1..8.
REQ-002 SHALL have parameter TRANS_ID_BITS, default 3: scoreboard transaction ID width.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port flush_i, input, 1 bit: pipeline flush.
REQ-006 SHALL have port issue_req_i, input, 1 bit: issue stage presents an FLU instruction.
REQ-007 SHALL have port issue_lat_i, input, $clog2(MAX_LAT+1) bits: fixed writeback latency. 0 covers ALU, branch, CSR and VALU; 1 covers the multiplier.
REQ-008 SHALL have port issue_div_i, input, 1 bit: the instruction is a variable-latency divide; issue_lat_i is ignored.
REQ-009 SHALL have port issue_trans_id_i, input, TRANS_ID_BITS bits: the instruction's scoreboard ID.
REQ-010 SHALL have port issue_grant_o, output, 1 bit: combinational grant; the instruction is accepted in this cycle.
REQ-011 SHALL have port div_done_i, input, 1 bit: the divider has a result ready.
REQ-012 SHALL have port div_trans_id_i, input, TRANS_ID_BITS bits: the ID of the divider result.
REQ-013 SHALL have port div_stall_o, output, 1 bit: the divider must hold its result this cycle.
REQ-014 SHALL have port div_busy_o, output, 1 bit: a divide is in flight.
REQ-015 SHALL have port wb_valid_o, output, 1 bit: the FLU write port is used this cycle.
REQ-016 SHALL have port wb_src_o, output, 2 bits: the port owner. 0 = none, 1 = latency-0 grant, 2 = reservation, 3 = divider.
REQ-017 SHALL have port wb_trans_id_o, output, TRANS_ID_BITS bits: the ID written back this cycle.
REQ-018 SHALL have port conflict_cnt_o, output, 16 bits: saturating count of refused issue cycles.

Function
REQ-019 SHALL keep a reservation table res_q[0..MAX_LAT-1], each entry holding a valid bit and an ID; entry k means the port is reserved at cycle now+k.
REQ-020 SHALL, every cycle, shift res_q[k] <= res_q[k+1] and load the top entry with invalid unless a new reservation targets it.
REQ-021 SHALL grant a latency-0 request only if res_q[0] is invalid: ~res_q[0].v.
REQ-022 SHALL grant a latency-L request, 1<=L<=MAX_LAT, only if the entry at index L is free after the shift; for L=MAX_LAT this is always true.
REQ-023 SHALL, on a latency-L grant with L>=1, write res_d[L-1] valid with issue_trans_id_i.
REQ-024 SHALL grant a divide only if div_busy_q is 0 or the in-flight divide completes this cycle; on grant it SHALL set div_busy_q and store no reservation.
REQ-025 SHALL force issue_grant_o to 0 whenever flush_i=1 or rst_ni=0.
REQ-026 SHALL set issue_grant_o to 0 for issue_lat_i>MAX_LAT (illegal latency).
REQ-027 SHALL assign write-port priority: reservation, then latency-0 grant, then divider.
REQ-028 SHALL drive div_stall_o = div_done_i & (res_q[0].v | latency-0 grant this cycle).
REQ-029 SHALL block a latency-0 request while div_done_i=1 and res_q[0] is free; the divider takes the port and the request is refused.
REQ-030 SHALL treat a divider result as accepted when div_done_i & ~div_stall_o; acceptance clears div_busy_q at the next edge unless a new divide is granted in the same cycle.
REQ-031 SHALL drive wb_valid_o, wb_src_o and wb_trans_id_o combinationally from the winning source; when the port is idle, wb_src_o=0 and wb_trans_id_o=0.
REQ-032 SHALL increment conflict_cnt_o in cycles where issue_req_i=1, issue_grant_o=0 and flush_i=0; it SHALL saturate at 16'hFFFF and SHALL NOT be cleared by flush.
REQ-033 SHALL, on flush_i, clear all res_q valid bits and div_busy_q at the next edge; wb_* outputs SHALL still reflect the current cycle.
REQ-034 SHALL require div_done_i to be 0 in the cycle after a flush; the divider flushes itself.
REQ-035 SHALL give latency-0 grants a same-cycle port and SHALL NOT write them into the table.

Reset
REQ-036 SHALL, when rst_ni=0 at a clock edge, clear every res_q entry (valid and ID), div_busy_q and conflict_cnt_o.
REQ-037 SHALL hold all outputs at 0 while rst_ni=0, regardless of other inputs.
REQ-038 SHALL discard all in-flight reservations and the divide on a reset mid-operation; no writeback is reported afterwards.

Verification (MAX_LAT=4, TRANS_ID_BITS=3)
REQ-039 SHALL cover: latency-1 issue of ID 2 at cycle 0, then latency-0 request at cycle 1 -> cycle-1 request refused; wb_src_o=2 and wb_trans_id_o=2 at cycle 1; conflict_cnt_o=1.
REQ-040 SHALL cover: latency-4 issue of ID 5 at cycle 0, then latency-3 issue at cycle 1 -> cycle-1 request refused; wb ID 5 at cycle 4 only.
REQ-041 SHALL cover: divide granted; at cycle 6 div_done_i=1 while res_q[0] is valid -> div_stall_o=1; divider result written at cycle 7 with wb_src_o=3; div_busy_o falls at cycle 8.
REQ-042 SHALL cover: three reservations pending plus div_busy, then flush_i pulse -> no wb_valid_o in the following 4 cycles; div_busy_o=0; a divide granted on the next request.
REQ-043 SHALL cover: issue_req_i held at 1 against a blocked slot for 70000 cycles -> conflict_cnt_o=16'hFFFF, no wrap.
REQ-044 SHALL cover: rst_ni=0 for 1 edge with a latency-3 reservation pending -> all outputs 0; no writeback in the following 3 cycles.

Source files
------------

// File: rtl/flu_wb_scheduler.sv
// Writeback-port scheduler for the fixed-latency unit: arbitrates the single FLU write port
// between latency-0 issues, fixed-latency reservations and a variable-latency divider.
module flu_wb_scheduler #(
   parameter int unsigned MAX_LAT       = 4,
   parameter int unsigned TRANS_ID_BITS = 3
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             flush_i,
   input  logic                             issue_req_i,
   input  logic [$clog2(MAX_LAT+1)-1:0]     issue_lat_i,
   input  logic                             issue_div_i,
   input  logic [TRANS_ID_BITS-1:0]         issue_trans_id_i,
   output logic                             issue_grant_o,
   input  logic                             div_done_i,
   input  logic [TRANS_ID_BITS-1:0]         div_trans_id_i,
   output logic                             div_stall_o,
   output logic                             div_busy_o,
   output logic                             wb_valid_o,
   output logic [1:0]                       wb_src_o,
   output logic [TRANS_ID_BITS-1:0]         wb_trans_id_o,
   output logic [15:0]                      conflict_cnt_o
);

   localparam int unsigned LatW = $clog2(MAX_LAT + 1);

   localparam logic [1:0] SrcNone = 2'd0;
   localparam logic [1:0] SrcLat0 = 2'd1;
   localparam logic [1:0] SrcRes  = 2'd2;
   localparam logic [1:0] SrcDiv  = 2'd3;

   typedef enum logic [0:0] {StIdle, StBusy} div_state_e;

   div_state_e div_state_q, div_state_d;

   logic [MAX_LAT-1:0]       res_v_q, res_v_d;
   logic [TRANS_ID_BITS-1:0] res_id_q [MAX_LAT];
   logic [TRANS_ID_BITS-1:0] res_id_d [MAX_LAT];
   logic [15:0]              conflict_cnt_q, conflict_cnt_d;

   logic can_issue;
   logic lat_zero;
   logic lat_legal;
   logic slot_free;
   logic lat0_grant;
   logic res_grant;
   logic div_grant;
   logic div_busy;
   logic div_stall;
   logic div_accept;
   logic grant;

   // ---------------------------------------------------------------------------------------
   // Issue arbitration
   // ---------------------------------------------------------------------------------------
   assign can_issue = issue_req_i & ~flush_i & rst_ni;
   assign lat_zero  = (issue_lat_i == '0);
   assign lat_legal = (issue_lat_i <= LatW'(MAX_LAT));

   // A latency-L issue needs entry L free; that slot lands in res_d[L-1] after the shift.
   always_comb begin
      slot_free = 1'b0;
      if (issue_lat_i == LatW'(MAX_LAT)) begin
         slot_free = 1'b1;
      end
      for (int unsigned k = 1; k < MAX_LAT; k++) begin
         if (issue_lat_i == LatW'(k)) begin
            slot_free = ~res_v_q[k];
         end
      end
   end

   // A pending divider result owns an otherwise free port, so latency-0 yields to it.
   assign lat0_grant = can_issue & ~issue_div_i & lat_zero & ~res_v_q[0] & ~div_done_i;
   assign res_grant  = can_issue & ~issue_div_i & ~lat_zero & lat_legal & slot_free;

   assign div_stall  = rst_ni & div_done_i & (res_v_q[0] | lat0_grant);
   assign div_accept = rst_ni & div_done_i & ~div_stall;
   assign div_grant  = can_issue & issue_div_i & (~div_busy | div_accept);

   assign grant = lat0_grant | res_grant | div_grant;

   // ---------------------------------------------------------------------------------------
   // Divider occupancy FSM
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         div_state_q <= StIdle;
      end else begin
         div_state_q <= div_state_d;
      end
   end

   always_comb begin
      div_state_d = div_state_q;
      if (flush_i) begin
         div_state_d = StIdle;
      end else if (div_grant) begin
         div_state_d = StBusy;
      end else if (div_accept) begin
         div_state_d = StIdle;
      end
   end

   always_comb begin
      div_busy = (div_state_q == StBusy);
   end

   // ---------------------------------------------------------------------------------------
   // Reservation table and conflict counter
   // ---------------------------------------------------------------------------------------
   always_comb begin
      for (int unsigned k = 0; k + 1 < MAX_LAT; k++) begin
         res_v_d[k]  = res_v_q[k+1];
         res_id_d[k] = res_id_q[k+1];
      end
      res_v_d[MAX_LAT-1]  = 1'b0;
      res_id_d[MAX_LAT-1] = '0;
      if (res_grant) begin
         for (int unsigned k = 0; k < MAX_LAT; k++) begin
            if (issue_lat_i == LatW'(k + 1)) begin
               res_v_d[k]  = 1'b1;
               res_id_d[k] = issue_trans_id_i;
            end
         end
      end
      if (flush_i) begin
         res_v_d = '0;
      end
   end

   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      if (issue_req_i && !grant && !flush_i && conflict_cnt_q != 16'hFFFF) begin
         conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         res_v_q        <= '0;
         res_id_q       <= '{default: '0};
         conflict_cnt_q <= '0;
      end else begin
         res_v_q        <= res_v_d;
         res_id_q       <= res_id_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Write-port ownership: reservation, then latency-0 grant, then divider
   // ---------------------------------------------------------------------------------------
   always_comb begin
      wb_valid_o    = 1'b0;
      wb_src_o      = SrcNone;
      wb_trans_id_o = '0;
      if (rst_ni) begin
         if (res_v_q[0]) begin
            wb_valid_o    = 1'b1;
            wb_src_o      = SrcRes;
            wb_trans_id_o = res_id_q[0];
         end else if (lat0_grant) begin
            wb_valid_o    = 1'b1;
            wb_src_o      = SrcLat0;
            wb_trans_id_o = issue_trans_id_i;
         end else if (div_accept) begin
            wb_valid_o    = 1'b1;
            wb_src_o      = SrcDiv;
            wb_trans_id_o = div_trans_id_i;
         end
      end
   end

   assign issue_grant_o  = grant;
   assign div_stall_o    = div_stall;
   assign div_busy_o     = rst_ni & div_busy;
   assign conflict_cnt_o = rst_ni ? conflict_cnt_q : 16'h0000;

endmodule

// File: tb/tb_flu_wb_scheduler.sv
// Directed bench for flu_wb_scheduler: expected writebacks go into a scoreboard queue keyed by
// cycle, and a negedge monitor pops and compares every write-port use.
module tb_flu_wb_scheduler;

   logic       clk = 1'b0;
   logic       rst_ni = 1'b0;
   logic       flush = 1'b0;
   logic       issue_req = 1'b0;
   logic [2:0] issue_lat = '0;
   logic       issue_div = 1'b0;
   logic [2:0] issue_id = '0;
   logic       issue_grant;
   logic       div_done = 1'b0;
   logic [2:0] div_id = '0;
   logic       div_stall;
   logic       div_busy;
   logic       wb_valid;
   logic [1:0] wb_src;
   logic [2:0] wb_id;
   logic [15:0] conflict_cnt;

   typedef struct {
      int         cyc;
      logic [1:0] src;
      logic [2:0] id;
   } wb_t;

   wb_t exp_q[$];
   int  cyc = 0;
   int  n_checks = 0;
   int  n_fail = 0;
   int  b;

   flu_wb_scheduler #(
      .MAX_LAT       (4),
      .TRANS_ID_BITS (3)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .flush_i          (flush),
      .issue_req_i      (issue_req),
      .issue_lat_i      (issue_lat),
      .issue_div_i      (issue_div),
      .issue_trans_id_i (issue_id),
      .issue_grant_o    (issue_grant),
      .div_done_i       (div_done),
      .div_trans_id_i   (div_id),
      .div_stall_o      (div_stall),
      .div_busy_o       (div_busy),
      .wb_valid_o       (wb_valid),
      .wb_src_o         (wb_src),
      .wb_trans_id_o    (wb_id),
      .conflict_cnt_o   (conflict_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every used write-port cycle must match a scoreboard entry for this cycle.
   always @(negedge clk) begin
      if (wb_valid === 1'b1) begin
         int idx;
         idx = -1;
         foreach (exp_q[i]) begin
            if (idx < 0 && exp_q[i].cyc == cyc) idx = i;
         end
         if (idx < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wb_unexpected: got src %0d id %0d, expected no writeback (cycle %0d)",
                     wb_src, wb_id, cyc);
         end else begin
            chk("wb_src", 32'(wb_src), 32'(exp_q[idx].src));
            chk("wb_id", 32'(wb_id), 32'(exp_q[idx].id));
            exp_q.delete(idx);
         end
      end else begin
         chk("wb_idle", {27'd0, wb_src, wb_id}, 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      issue_req = 1'b0;
      issue_div = 1'b0;
      issue_lat = '0;
      issue_id  = '0;
      flush     = 1'b0;
      div_done  = 1'b0;
      div_id    = '0;
   endtask

   task automatic issue(input int lat, input logic div, input int id);
      issue_req = 1'b1;
      issue_lat = 3'(lat);
      issue_div = div;
      issue_id  = 3'(id);
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic push(input int c, input logic [1:0] src, input int id);
      wb_t e;
      e.cyc = c;
      e.src = src;
      e.id  = 3'(id);
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      tick();
      rst_ni = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
   endtask

   initial begin
      do_reset();
      tick(); b = cyc;
      settle();
      chk("rst_grant", 32'(issue_grant), 32'd0);
      chk("rst_busy", 32'(div_busy), 32'd0);
      chk("rst_cnt", 32'(conflict_cnt), 32'd0);

      // Latency-1 reservation blocks a latency-0 request in the next cycle.
      tick(); b = cyc; issue(1, 0, 2); settle();
      chk("s1_lat1_grant", 32'(issue_grant), 32'd1);
      push(b + 1, 2'd2, 2);
      tick(); issue(0, 0, 3); settle();
      chk("s1_lat0_blocked", 32'(issue_grant), 32'd0);
      tick(); issue(0, 0, 4); settle();
      chk("s1_cnt", 32'(conflict_cnt), 32'd1);
      chk("s1_lat0_grant", 32'(issue_grant), 32'd1);
      push(b + 2, 2'd1, 4);
      tick(); issue(2, 0, 5); settle();
      chk("s1_lat2_grant", 32'(issue_grant), 32'd1);
      push(b + 5, 2'd2, 5);
      tick(); issue(1, 0, 6); settle();
      chk("s1_lat1_blocked", 32'(issue_grant), 32'd0);
      tick();
      tick(); settle();
      chk("s1_cnt2", 32'(conflict_cnt), 32'd2);

      // Latency-4 slot blocks a later latency-3; illegal latency refused.
      do_reset();
      tick(); b = cyc; issue(4, 0, 5); settle();
      chk("s2_lat4_grant", 32'(issue_grant), 32'd1);
      push(b + 4, 2'd2, 5);
      tick(); issue(3, 0, 6); settle();
      chk("s2_lat3_blocked", 32'(issue_grant), 32'd0);
      tick(); issue(5, 0, 1); settle();
      chk("s2_illegal_lat", 32'(issue_grant), 32'd0);
      tick(); issue(4, 0, 7); settle();
      chk("s2_lat4_again", 32'(issue_grant), 32'd1);
      push(b + 7, 2'd2, 7);
      repeat (5) tick();
      settle();
      chk("s2_cnt", 32'(conflict_cnt), 32'd2);

      // Divider stalled by a reservation, then wins the port; back-to-back divide.
      do_reset();
      tick(); b = cyc; issue(0, 1, 1); settle();
      chk("s3_div_grant", 32'(issue_grant), 32'd1);
      tick(); issue(0, 1, 2); settle();
      chk("s3_div_busy_refuse", 32'(issue_grant), 32'd0);
      repeat (3) tick();
      tick(); issue(1, 0, 3); settle();
      chk("s3_lat1_grant", 32'(issue_grant), 32'd1);
      push(b + 6, 2'd2, 3);
      tick(); div_done = 1'b1; div_id = 3'd1; settle();
      chk("s3_stall", 32'(div_stall), 32'd1);
      chk("s3_busy6", 32'(div_busy), 32'd1);
      tick(); div_done = 1'b1; div_id = 3'd1; issue(0, 0, 4); settle();
      push(b + 7, 2'd3, 1);
      chk("s3_nostall", 32'(div_stall), 32'd0);
      chk("s3_lat0_yields", 32'(issue_grant), 32'd0);
      chk("s3_busy7", 32'(div_busy), 32'd1);
      tick(); settle();
      chk("s3_busy8", 32'(div_busy), 32'd0);
      tick(); issue(0, 1, 5); settle();
      chk("s3_div2_grant", 32'(issue_grant), 32'd1);
      chk("s3_cnt", 32'(conflict_cnt), 32'd2);
      tick();
      tick();
      tick(); div_done = 1'b1; div_id = 3'd5; issue(0, 1, 6); settle();
      chk("s3_div3_same_cycle", 32'(issue_grant), 32'd1);
      push(b + 12, 2'd3, 5);
      tick(); settle();
      chk("s3_busy13", 32'(div_busy), 32'd1);

      // Flush drops three reservations and the divide.
      do_reset();
      tick(); b = cyc; issue(0, 1, 0); settle();
      chk("s4_div_grant", 32'(issue_grant), 32'd1);
      for (int i = 1; i <= 3; i++) begin
         tick(); issue(4, 0, i); settle();
         chk("s4_lat4_grant", 32'(issue_grant), 32'd1);
      end
      tick(); flush = 1'b1; issue(0, 0, 4); settle();
      chk("s4_flush_grant", 32'(issue_grant), 32'd0);
      chk("s4_busy_flush", 32'(div_busy), 32'd1);
      tick(); issue(0, 1, 5); settle();
      chk("s4_busy_after", 32'(div_busy), 32'd0);
      chk("s4_div_regrant", 32'(issue_grant), 32'd1);
      repeat (4) tick();
      settle();
      chk("s4_cnt", 32'(conflict_cnt), 32'd0);

      // Reset mid-operation with a reservation in slot 0 and a divide in flight.
      do_reset();
      tick(); b = cyc; issue(0, 1, 0); settle();
      chk("s5_div_grant", 32'(issue_grant), 32'd1);
      tick(); issue(3, 0, 7); settle();
      chk("s5_lat3_grant", 32'(issue_grant), 32'd1);
      tick(); issue(1, 0, 6); settle();
      chk("s5_lat1_grant", 32'(issue_grant), 32'd1);
      push(b + 3, 2'd2, 6);
      tick(); issue(5, 0, 1); settle();
      chk("s5_cnt_pre", 32'(conflict_cnt), 32'd0);
      tick(); rst_ni = 1'b0; issue(0, 0, 2); div_done = 1'b1; div_id = 3'd3; settle();
      chk("s5_rst_grant", 32'(issue_grant), 32'd0);
      chk("s5_rst_wb", 32'(wb_valid), 32'd0);
      chk("s5_rst_stall", 32'(div_stall), 32'd0);
      chk("s5_rst_busy", 32'(div_busy), 32'd0);
      chk("s5_rst_cnt", 32'(conflict_cnt), 32'd0);
      tick(); rst_ni = 1'b1;
      repeat (3) tick();
      settle();
      chk("s5_cnt_post", 32'(conflict_cnt), 32'd0);
      chk("s5_busy_post", 32'(div_busy), 32'd0);

      // Conflict counter saturates against a busy divider.
      do_reset();
      tick(); issue(0, 1, 0); settle();
      chk("s6_div_grant", 32'(issue_grant), 32'd1);
      repeat (70000) begin
         tick(); issue(0, 1, 1);
      end
      settle();
      chk("s6_refused", 32'(issue_grant), 32'd0);
      chk("s6_saturated", 32'(conflict_cnt), 32'h0000FFFF);
      tick();
      tick(); settle();

      chk("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
